// File: rtl/mcd_step_decoder.sv
// mcd_step_decoder -- receive-side monitor for a 4-phase one-hot stepper drive bus.
// It synchronizes the phase code and recovers step events and their direction.
// It also keeps a wrapping signed position count, and flags illegal codes,
// skipped phases and stalls.
//
// Ports:
//   clk_i         clock, all logic on posedge
//   rst_i         synchronous reset, active-high
//   phase_i[3:0]  drive-bus phase code (0000 idle, one-hot active)
//   pos_clr_i     pulse: clear position (wins over a coincident step)
//   err_clr_i     pulse: leave FAULT (ignored elsewhere)
//   step_pulse_o  1-cycle pulse per legal step
//   step_dir_o    direction of last legal step (1 = index up)
//   position_o    two's-complement step count, wraps silently
//   active_o      1 while tracking
//   err_o         1 while faulted
//   stall_o       1 while the phase is held >= STALL_CYCLES while tracking
module mcd_step_decoder #(
  parameter int POS_W        = 16,
  parameter int STALL_CYCLES = 1000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       phase_i,
  input  logic             pos_clr_i,
  input  logic             err_clr_i,
  output logic             step_pulse_o,
  output logic             step_dir_o,
  output logic [POS_W-1:0] position_o,
  output logic             active_o,
  output logic             err_o,
  output logic             stall_o
);

  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FAULT} state_t;

  state_t                      state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [1:0]                  last_q, last_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [POS_W-1:0]            pos_d;
  logic                        pulse_d, dir_d, stall_d;

  logic [3:0] ps;
  logic       onehot, illegal;
  logic [1:0] idx, delta;

  assign ps      = sync_q[SYNC_STAGES-1];
  assign onehot  = (ps != 4'd0) && ((ps & (ps - 4'd1)) == 4'd0);
  assign illegal = (ps != 4'd0) && !onehot;
  // Mod-4 distance from the stored phase: 1 = up, 3 = down, 2 = skipped phase.
  assign delta   = idx - last_q;

  always_comb begin
    idx = 2'd0;
    case (ps)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pos_d   = position_o;
    pulse_d = 1'b0;
    dir_d   = step_dir_o;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (illegal) begin
          state_d = S_FAULT;
        end else if (onehot) begin
          // Entry only records where the rotor is; it is not a step.
          state_d = S_TRACK;
          last_d  = idx;
        end
      end
      S_TRACK: begin
        if (ps == 4'd0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (illegal) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          case (delta)
            2'd0: if (cnt_q < STALL_MAX) cnt_d = cnt_q + CNT_W'(1);
            2'd1: begin
              pulse_d = 1'b1;
              dir_d   = 1'b1;
              pos_d   = position_o + POS_W'(1);
              last_d  = idx;
              cnt_d   = '0;
            end
            2'd3: begin
              pulse_d = 1'b1;
              dir_d   = 1'b0;
              pos_d   = position_o - POS_W'(1);
              last_d  = idx;
              cnt_d   = '0;
            end
            default: begin
              state_d = S_FAULT;
              cnt_d   = '0;
            end
          endcase
        end
      end
      S_FAULT: begin
        cnt_d = '0;
        if (err_clr_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pos_clr_i) pos_d = '0;
    // Derived from next-state values so stall drops on the same edge the counter clears.
    stall_d = (state_d == S_TRACK) && (cnt_d >= STALL_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
      step_pulse_o <= 1'b0;
      step_dir_o   <= 1'b0;
      position_o   <= '0;
      active_o     <= 1'b0;
      err_o        <= 1'b0;
      stall_o      <= 1'b0;
    end else begin
      sync_q[0] <= phase_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      step_pulse_o <= pulse_d;
      step_dir_o   <= dir_d;
      position_o   <= pos_d;
      active_o     <= (state_d == S_TRACK);
      err_o        <= (state_d == S_FAULT);
      stall_o      <= stall_d;
    end
  end

endmodule

// File: tb/tb_mcd_step_decoder.sv
module tb_mcd_step_decoder;
  localparam int POS_W = 4, STALL = 5, SS = 2;
  localparam int MOD = 1 << POS_W;

  logic clk = 1'b0, rst = 1'b0, pos_clr = 1'b0, err_clr = 1'b0;
  logic [3:0] phase = 4'd0;
  logic step_pulse, step_dir, active, err, stall;
  logic [POS_W-1:0] position;

  int checks = 0, failures = 0, seen = 0;

  // Reference model: behavioural, integer position mod 2^POS_W, phase delay as a queue.
  bit m_trk, m_flt, m_pulse, m_dir;
  int m_pos, m_last, m_held;
  logic [3:0] dq[$];

  mcd_step_decoder #(.POS_W(POS_W), .STALL_CYCLES(STALL), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_i(rst), .phase_i(phase), .pos_clr_i(pos_clr), .err_clr_i(err_clr),
    .step_pulse_o(step_pulse), .step_dir_o(step_dir), .position_o(position),
    .active_o(active), .err_o(err), .stall_o(stall));

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_trk = 0; m_flt = 0; m_pulse = 0; m_dir = 0; m_pos = 0; m_last = 0; m_held = 0;
    dq.delete();
    for (int i = 0; i < SS; i++) dq.push_back(4'd0);
  endtask

  task automatic m_step(input logic [3:0] ph, input bit pclr, input bit eclr);
    logic [3:0] ps;
    int d;
    dq.push_back(ph);
    ps = dq.pop_front();
    m_pulse = 0;
    if (m_flt) begin
      if (eclr) m_flt = 0;
    end else if (!m_trk) begin
      if ($countones(ps) == 1) begin m_trk = 1; m_last = idx_of(ps); m_held = 0; end
      else if (ps != 0) m_flt = 1;
    end else begin
      if (ps == 0) begin m_trk = 0; m_held = 0; end
      else if ($countones(ps) != 1) begin m_trk = 0; m_flt = 1; end
      else begin
        d = (idx_of(ps) - m_last + 4) % 4;
        if (d == 0) begin
          if (m_held < STALL) m_held++;
        end else if (d == 2) begin
          m_trk = 0; m_flt = 1;
        end else begin
          m_pulse = 1;
          m_dir   = (d == 1);
          m_pos   = (d == 1) ? (m_pos + 1) % MOD : (m_pos + MOD - 1) % MOD;
          m_last  = idx_of(ps);
          m_held  = 0;
        end
      end
    end
    if (pclr) m_pos = 0;
  endtask

  task automatic cyc(input logic [3:0] ph, input bit pclr = 0, input bit eclr = 0);
    logic [POS_W-1:0] mp;
    phase = ph; pos_clr = pclr; err_clr = eclr;
    @(posedge clk);
    if (rst) m_reset(); else m_step(ph, pclr, eclr);
    #1;
    mp = m_pos[POS_W-1:0];
    chk("pulse", step_pulse, m_pulse);
    chk("dir", step_dir, m_dir);
    chk("position", position, mp);
    chk("active", active, m_trk);
    chk("err", err, m_flt);
    chk("stall", stall, m_trk && (m_held >= STALL));
    if (step_pulse === 1'b1) seen++;
  endtask

  task automatic hold(input logic [3:0] ph, input int n);
    for (int i = 0; i < n; i++) cyc(ph);
  endtask

  initial begin
    logic [3:0] ph;
    int cur, r, n;
    m_reset();
    // reset
    rst = 1; cyc(4'd0); cyc(4'd0); rst = 0;
    chk("rst_position", position, 0);
    chk("rst_active", active, 0);

    // 1: up sequence
    seen = 0;
    hold(4'b0000, 4); hold(4'b0001, 4); hold(4'b0010, 4);
    hold(4'b0100, 4); hold(4'b1000, 4); hold(4'b0001, 4);
    chk("t1_pulses", seen, 4); chk("t1_dir", step_dir, 1);
    chk("t1_pos", position, 4); chk("t1_err", err, 0);

    // 2: down sequence
    seen = 0;
    hold(4'b1000, 4); hold(4'b0100, 4); hold(4'b0010, 4); hold(4'b0001, 4);
    chk("t2_pulses", seen, 4); chk("t2_dir", step_dir, 0); chk("t2_pos", position, 0);

    // 3: skipped phase, then recover
    seen = 0;
    hold(4'b0100, 4);
    chk("t3_err", err, 1); chk("t3_pulses", seen, 0); chk("t3_pos", position, 0);
    hold(4'b0010, 2); cyc(4'b0010, 0, 1); hold(4'b0010, 3);
    chk("t3_resync_err", err, 0); chk("t3_resync_active", active, 1);
    chk("t3_resync_pulses", seen, 0);

    // 4: illegal code in TRACK and in IDLE
    hold(4'b0011, 4);
    chk("t4_trk_err", err, 1); chk("t4_trk_active", active, 0);
    cyc(4'b0011, 0, 1); hold(4'b0011, 3);
    chk("t4_idle_err", err, 1); chk("t4_idle_active", active, 0);
    hold(4'b0000, 3); cyc(4'b0000, 0, 1); hold(4'b0000, 2);
    chk("t4_clr_err", err, 0);

    // 5: wrap at POS_W=4 and pos_clr coincident with a step
    cyc(4'b0000, 1, 0);
    hold(4'b0001, 4);
    for (int k = 0; k < 8; k++) begin
      ph = 4'b0001 << ((k + 1) % 4);
      hold(ph, 4);
    end
    chk("t5_wrap", position, 4'b1000);
    cyc(4'b0010); cyc(4'b0010); cyc(4'b0010, 1, 0);
    chk("t5_clr_pulse", step_pulse, 1); chk("t5_clr_pos", position, 0);
    hold(4'b0010, 2);

    // 6: stall, cleared by a step; reset mid-TRACK
    hold(4'b0010, 8);
    chk("t6_stall", stall, 1);
    hold(4'b0100, 3);
    chk("t6_stall_clr", stall, 0); chk("t6_step_dir", step_dir, 1);
    hold(4'b0100, 8);
    rst = 1; cyc(4'b0100); rst = 0;
    chk("t6_rst_pos", position, 0); chk("t6_rst_dir", step_dir, 0);
    chk("t6_rst_active", active, 0); chk("t6_rst_stall", stall, 0);
    seen = 0;
    hold(4'b0100, 4);
    chk("t6_entry_pulses", seen, 0); chk("t6_entry_active", active, 1);

    // random traffic against the model
    cur = 2;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       cur = (cur + 1) % 4;
      else if (r < 11) cur = (cur + 3) % 4;
      else if (r == 12) cur = (cur + 2) % 4;
      ph = 4'b0001 << cur;
      if (r == 13) ph = 4'd0;
      if (r == 14) begin
        ph = 4'd3;
        while ($countones(ph) < 2) ph = 4'($urandom_range(3, 15));
      end
      if (r == 15) ph = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 99) == 0) rst = 1;
      for (int j = 0; j < n; j++) begin
        cyc(ph, $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0);
        rst = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
